// File: rtl/cpu_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_sequencer_if
// Description : Trace drain port of the CPU step sequencer. The sequencer is
//               the master (it offers entries), the debug host is the slave
//               (it accepts them with trace_ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_sequencer_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
);
    logic                        trace_valid;
    logic                        trace_ready;
    logic [WORDSIZE-1:0]         trace_pc;
    logic [INSTRUCTION_SIZE-1:0] trace_instr;

    modport master (
        output trace_valid,
        output trace_pc,
        output trace_instr,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_pc,
        input  trace_instr,
        output trace_ready
    );
endinterface
`default_nettype wire

// File: rtl/cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_sequencer
// Description : Generates the per-instruction strobe sequence for the
//               single-cycle CPU (settle -> cpu_clk pulse -> pc_clk pulse),
//               in single-step or free-run mode, and records (PC, instr) of
//               each executed instruction in a small trace FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_sequencer #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int SETTLE_CYCLES    = 4,
    parameter int PULSE_CYCLES     = 2,
    parameter int TRACE_DEPTH      = 4,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        step,
    input  logic                        halt_req,
    input  logic [WORDSIZE-1:0]         cpu_pc_addr,
    input  logic [INSTRUCTION_SIZE-1:0] cpu_instr,
    output logic                        cpu_clk,
    output logic                        pc_clk,
    output logic                        busy,
    output logic [CNT_W-1:0]            retired_count,
    output logic                        trace_overflow,
    cpu_step_sequencer_if.master        trace
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PH_MAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
    localparam int PH_W   = ($clog2(PH_MAX) > 0) ? $clog2(PH_MAX) : 1;
    localparam int AW     = $clog2(TRACE_DEPTH);
    localparam int EW     = WORDSIZE + INSTRUCTION_SIZE;

    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] PULSE_LAST  = PH_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CPU_HI = 3'd2,
        ST_CPU_LO = 3'd3,
        ST_PC_HI  = 3'd4,
        ST_PC_LO  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [PH_W-1:0]   phase_q;
    logic              cpu_clk_q;
    logic              pc_clk_q;
    logic              busy_q;
    logic [CNT_W-1:0]  retired_q;

    logic w_start;
    logic w_phase_done;
    logic w_push;

    // A start needs a request and no pending halt; run+step is one start.
    assign w_start      = (step || run) && !halt_req;
    assign w_phase_done = (state_q == ST_SETTLE) ? (phase_q == SETTLE_LAST)
                                                 : (phase_q == PULSE_LAST);
    // Capture the PC/instruction on the final settle cycle, before writeback.
    assign w_push       = (state_q == ST_SETTLE) && (phase_q == SETTLE_LAST);

    // Sequencer FSM with registered strobes, busy and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            cpu_clk_q <= 1'b0;
            pc_clk_q  <= 1'b0;
            busy_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (w_start) begin
                    state_q <= ST_SETTLE;
                    phase_q <= '0;
                    busy_q  <= 1'b1;
                end
            end else if (!w_phase_done) begin
                phase_q <= phase_q + PH_W'(1);
            end else begin
                phase_q <= '0;
                case (state_q)
                    ST_SETTLE: begin
                        state_q   <= ST_CPU_HI;
                        cpu_clk_q <= 1'b1;
                    end
                    ST_CPU_HI: begin
                        state_q   <= ST_CPU_LO;
                        cpu_clk_q <= 1'b0;
                    end
                    ST_CPU_LO: begin
                        state_q   <= ST_PC_HI;
                        pc_clk_q  <= 1'b1;
                        retired_q <= retired_q + CNT_W'(1);
                    end
                    ST_PC_HI: begin
                        state_q  <= ST_PC_LO;
                        pc_clk_q <= 1'b0;
                    end
                    ST_PC_LO: begin
                        // Instruction boundary: the only place run/halt matter.
                        if (run && !halt_req) begin
                            state_q <= ST_SETTLE;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        cpu_clk_q <= 1'b0;
                        pc_clk_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cpu_clk       = cpu_clk_q;
    assign pc_clk        = pc_clk_q;
    assign busy          = busy_q;
    assign retired_count = retired_q;

    // ------------------------------------------------------------------
    // Trace FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [EW-1:0]  mem_q [TRACE_DEPTH];
    logic [AW:0]    wr_q;
    logic [AW:0]    rd_q;
    logic [AW:0]    wr_d;
    logic [AW:0]    rd_d;
    logic [EW-1:0]  head_q;
    logic [EW-1:0]  head_d;
    logic           ovf_q;

    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push_ok;
    logic           w_drop;
    logic [EW-1:0]  w_entry;

    assign w_entry   = {cpu_pc_addr, cpu_instr};
    assign w_empty   = (wr_q == rd_q);
    assign w_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_pop     = !w_empty && trace.trace_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // Next pointers and next head entry; the head holds when the FIFO drains.
    always_comb begin
        rd_d   = w_pop     ? rd_q + (AW+1)'(1) : rd_q;
        wr_d   = w_push_ok ? wr_q + (AW+1)'(1) : wr_q;
        head_d = head_q;
        if (rd_d != wr_d) begin
            if (w_push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
                head_d = w_entry;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    // Storage array; written only while the sequencer is in SETTLE.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_q[AW-1:0]] <= w_entry;
        end
    end

    // Pointers, registered head entry and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign trace.trace_valid = !w_empty;
    assign trace.trace_pc    = head_q[EW-1:INSTRUCTION_SIZE];
    assign trace.trace_instr = head_q[INSTRUCTION_SIZE-1:0];
    assign trace_overflow    = ovf_q;

endmodule
`default_nettype wire
